// File: rtl/spi_issue_arbiter_if.sv
// Request/issue bundle between the three instruction sources, the arbiter and master_spi.
// The slave modport is the arbiter's view. The master modport is the requester/consumer view.
interface spi_issue_arbiter_if #(
    parameter int IW = 32
);
    logic [2:0]    req_valid;
    logic [IW-1:0] req_instr_self;
    logic [IW-1:0] req_instr_left;
    logic [IW-1:0] req_instr_right;
    logic [2:0]    req_ready;
    logic [1:0]    spi_enable;
    logic [IW-1:0] spi_instr;
    logic          spi_start;
    logic          busy;

    modport slave (
        input  req_valid, req_instr_self, req_instr_left, req_instr_right,
        output req_ready, spi_enable, spi_instr, spi_start, busy
    );

    modport master (
        output req_valid, req_instr_self, req_instr_left, req_instr_right,
        input  req_ready, spi_enable, spi_instr, spi_start, busy
    );
endinterface

// File: rtl/spi_issue_arbiter.sv
// Round-robin arbiter feeding one master_spi instruction port from self/left/right sources.
// Each winning instruction is issued for one cycle and then held for HOLD_CYCLES cycles.
module spi_issue_arbiter #(
    parameter int HOLD_CYCLES = 32,
    parameter int IW          = 32
) (
    input  logic             clk,
    input  logic             reset,
    spi_issue_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [1:0] SRC_RIGHT = 2'd2;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [IW-1:0] instr_q, instr_d;

    logic [1:0]    cand_src [3];
    logic [2:0]    cand_valid;
    logic [1:0]    grant_idx;
    logic          grant_any;
    logic [IW-1:0] granted_instr;
    logic [2:0]    ready;

    // Source index visited at search position 'step' (0..2) after the last grantee.
    function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [2:0] step);
        logic [2:0] sum;
        sum = {1'b0, last} + step + 3'd1;
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            assign cand_src[gi]   = rr_next(last_q, 3'(gi));
            assign cand_valid[gi] = bus.req_valid[cand_src[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
        for (int p = 2; p >= 0; p--) begin
            if (cand_valid[p]) begin
                grant_idx = cand_src[p];
                grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        granted_instr = bus.req_instr_self;
        case (grant_idx)
            2'd1:    granted_instr = bus.req_instr_left;
            2'd2:    granted_instr = bus.req_instr_right;
            default: granted_instr = bus.req_instr_self;
        endcase
    end

    // Accept is only offered in IDLE and never while reset is being applied.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ready
            assign ready[gi] = (state_q == ST_IDLE) && !reset && grant_any
                               && (grant_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    instr_d = granted_instr;
                    last_d  = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = HOLD_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= SRC_RIGHT;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            instr_q <= instr_d;
        end
    end

    // Enable codes coincide with source indices; IDLE parks the port at 2'b11.
    assign bus.req_ready  = ready;
    assign bus.spi_enable = (state_q == ST_IDLE) ? 2'b11 : last_q;
    assign bus.spi_instr  = instr_q;
    assign bus.spi_start  = (state_q == ST_ISSUE);
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_spi_issue_arbiter.sv
// Directed bench for spi_issue_arbiter: scoreboard of expected issues plus timing/boundary checks.
// dut_a uses HOLD_CYCLES=4, dut_b uses HOLD_CYCLES=1.
module tb_spi_issue_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    spi_issue_arbiter_if #(.IW(32)) bus_a ();
    spi_issue_arbiter_if #(.IW(32)) bus_b ();

    spi_issue_arbiter #(.HOLD_CYCLES(4), .IW(32)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    spi_issue_arbiter #(.HOLD_CYCLES(1), .IW(32)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct packed {
        logic [1:0]  en;
        logic [31:0] instr;
    } txn_t;

    txn_t exp_a[$];
    txn_t exp_b[$];
    txn_t ta;
    txn_t tb_t;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Scoreboards: every spi_start must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_a.spi_start === 1'b1) begin
            chk("sb_a_pending", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) begin
                ta = exp_a.pop_front();
                $display("txn a: enable=%b instr=%0d (expected enable=%b instr=%0d)",
                         bus_a.spi_enable, bus_a.spi_instr, ta.en, ta.instr);
                chk("sb_a_enable", 64'(bus_a.spi_enable), 64'(ta.en));
                chk("sb_a_instr", 64'(bus_a.spi_instr), 64'(ta.instr));
            end
        end
        if (bus_b.spi_start === 1'b1) begin
            chk("sb_b_pending", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) begin
                tb_t = exp_b.pop_front();
                $display("txn b: enable=%b instr=%0d (expected enable=%b instr=%0d)",
                         bus_b.spi_enable, bus_b.spi_instr, tb_t.en, tb_t.instr);
                chk("sb_b_enable", 64'(bus_b.spi_enable), 64'(tb_t.en));
                chk("sb_b_instr", 64'(bus_b.spi_instr), 64'(tb_t.instr));
            end
        end
    end

    initial begin
        int last_start;
        int nstart;
        int got;
        int low_cnt;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req_valid       = 3'b000;
        bus_a.req_instr_self  = 32'd0;
        bus_a.req_instr_left  = 32'd0;
        bus_a.req_instr_right = 32'd0;
        bus_b.req_valid       = 3'b000;
        bus_b.req_instr_self  = 32'd0;
        bus_b.req_instr_left  = 32'd0;
        bus_b.req_instr_right = 32'd0;
        step();
        step();

        // Reset state, and valid during reset is neither accepted nor offered ready.
        chk("rst_enable", 64'(bus_a.spi_enable), 64'd3);
        chk("rst_instr", 64'(bus_a.spi_instr), 64'd0);
        chk("rst_start", 64'(bus_a.spi_start), 64'd0);
        chk("rst_busy", 64'(bus_a.busy), 64'd0);
        bus_a.req_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(bus_a.req_ready), 64'd0);
        step();
        chk("rst_valid_busy", 64'(bus_a.busy), 64'd0);
        chk("rst_valid_start", 64'(bus_a.spi_start), 64'd0);
        rst_a = 1'b0;
        bus_a.req_valid = 3'b000;
        #1;
        chk("idle_ready_none", 64'(bus_a.req_ready), 64'd0);

        // Single self request and the full busy window.
        bus_a.req_instr_self = 32'd10000;
        bus_a.req_valid      = 3'b001;
        #1;
        chk("t1_ready", 64'(bus_a.req_ready), 64'd1);
        exp_a.push_back(txn_t'{en: 2'b00, instr: 32'd10000});
        step();
        bus_a.req_valid = 3'b000;
        chk("t1_start", 64'(bus_a.spi_start), 64'd1);
        chk("t1_busy", 64'(bus_a.busy), 64'd1);
        chk("t1_ready_issue", 64'(bus_a.req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_hold_busy", 64'(bus_a.busy), 64'd1);
            chk("t1_hold_start", 64'(bus_a.spi_start), 64'd0);
        end
        step();
        chk("t1_end_busy", 64'(bus_a.busy), 64'd0);
        chk("t1_end_enable", 64'(bus_a.spi_enable), 64'd3);
        chk("t1_end_instr", 64'(bus_a.spi_instr), 64'd10000);

        // All three continuously valid: self, left, right, self at 6-cycle spacing.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        bus_a.req_instr_self  = 32'd30000;
        bus_a.req_instr_left  = 32'd50000;
        bus_a.req_instr_right = 32'd10000;
        exp_a.push_back(txn_t'{en: 2'b00, instr: 32'd30000});
        exp_a.push_back(txn_t'{en: 2'b01, instr: 32'd50000});
        exp_a.push_back(txn_t'{en: 2'b10, instr: 32'd10000});
        exp_a.push_back(txn_t'{en: 2'b00, instr: 32'd30000});
        bus_a.req_valid = 3'b111;
        last_start = 0;
        nstart     = 0;
        for (int i = 0; i < 60 && nstart < 4; i++) begin
            step();
            if (bus_a.spi_start === 1'b1) begin
                if (nstart > 0) chk("t2_spacing", 64'(cyc - last_start), 64'd6);
                last_start = cyc;
                nstart++;
            end
        end
        chk("t2_starts", 64'(nstart), 64'd4);

        // Left alone, twice in a row; its instr changes during HOLD.
        bus_a.req_valid = 3'b010;
        exp_a.push_back(txn_t'{en: 2'b01, instr: 32'd50000});
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if (bus_a.spi_start === 1'b1) got = 1;
        end
        chk("t3_first_left_seen", 64'(got), 64'd1);
        last_start = cyc;
        step();
        bus_a.req_instr_left = 32'd7;
        exp_a.push_back(txn_t'{en: 2'b01, instr: 32'd7});
        chk("t4_hold_instr", 64'(bus_a.spi_instr), 64'd50000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_instr", 64'(bus_a.spi_instr), 64'd50000);
            chk("t4_hold_enable", 64'(bus_a.spi_enable), 64'd1);
        end
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if (bus_a.spi_start === 1'b1) got = 1;
        end
        chk("t3_second_left_seen", 64'(got), 64'd1);
        chk("t3_left_spacing", 64'(cyc - last_start), 64'd6);
        bus_a.req_valid = 3'b000;

        // Reset on the second HOLD cycle drops the transaction; self wins afterwards.
        step();
        step();
        rst_a = 1'b1;
        bus_a.req_valid = 3'b111;
        #1;
        chk("t5_ready_in_reset", 64'(bus_a.req_ready), 64'd0);
        step();
        chk("t5_busy", 64'(bus_a.busy), 64'd0);
        chk("t5_enable", 64'(bus_a.spi_enable), 64'd3);
        chk("t5_start", 64'(bus_a.spi_start), 64'd0);
        chk("t5_instr", 64'(bus_a.spi_instr), 64'd0);
        rst_a = 1'b0;
        #1;
        chk("t5_ready_self", 64'(bus_a.req_ready), 64'd1);
        exp_a.push_back(txn_t'{en: 2'b00, instr: 32'd30000});
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if (bus_a.spi_start === 1'b1) got = 1;
        end
        chk("t5_self_seen", 64'(got), 64'd1);
        bus_a.req_valid = 3'b000;
        for (int i = 0; i < 6; i++) step();
        chk("t5_drain_busy", 64'(bus_a.busy), 64'd0);

        // HOLD_CYCLES=1 with continuous self request: 3-cycle cadence, one idle cycle.
        bus_b.req_instr_self = 32'd4242;
        bus_b.req_valid      = 3'b001;
        for (int i = 0; i < 3; i++) exp_b.push_back(txn_t'{en: 2'b00, instr: 32'd4242});
        rst_b = 1'b0;
        nstart     = 0;
        low_cnt    = 0;
        last_start = 0;
        for (int i = 0; i < 40 && nstart < 3; i++) begin
            step();
            if (bus_b.spi_start === 1'b1) begin
                if (nstart > 0) begin
                    chk("t6_spacing", 64'(cyc - last_start), 64'd3);
                    chk("t6_idle_cycles", 64'(low_cnt), 64'd1);
                end
                low_cnt    = 0;
                last_start = cyc;
                nstart++;
            end else if (bus_b.busy === 1'b0) begin
                low_cnt++;
            end
        end
        chk("t6_starts", 64'(nstart), 64'd3);
        bus_b.req_valid = 3'b000;
        for (int i = 0; i < 5; i++) step();

        chk("sb_a_leftover", 64'(exp_a.size()), 64'd0);
        chk("sb_b_leftover", 64'(exp_b.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spi_issue_arbiter.md
Name: spi_issue_arbiter

Overview:
- Shares the single master_spi instruction port among three requesters: self, left neighbour and right neighbour.
- Round-robin arbitration. Captures the winning 32-bit instruction, presents it to master_spi with the matching enable code, then holds it stable for a fixed serialisation window before granting again.
- Sits directly upstream of master_spi in each network node.

Parameters:
- HOLD_CYCLES, 32: cycles the instruction is held after the issue cycle (one per serial bit); legal range 1..255.
- IW, 32: instruction width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  3  request per source; bit0=self, bit1=left, bit2=right
- req_instr_self  input  IW  instruction from self
- req_instr_left  input  IW  instruction from left
- req_instr_right  input  IW  instruction from right
- req_ready  output  3  one-hot accept; a transfer occurs on a bit where valid & ready at the rising edge
- spi_enable  output  2  to master_spi enable: 2'b00 self, 2'b01 left, 2'b10 right, 2'b11 parked/idle
- spi_instr  output  IW  to master_spi in_instr
- spi_start  output  1  one-cycle pulse marking the first cycle of a new instruction
- busy  output  1  high in ISSUE and HOLD

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, spi_enable=2'b11, spi_instr=0, spi_start=0, busy=0, req_ready=0.
  - hold counter=0; round-robin pointer last=right, so self has first priority after reset.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - req_ready is combinational: one-hot grant of the first valid source in order last+1, last+2, last+3 (mod 3). It is 0 if no valid is asserted.
  - On an edge with any valid: capture the granted instruction into spi_instr, set spi_enable to that source's code, set last to the granted source, go to ISSUE.
  - With no valid: stay in IDLE; outputs keep their values, except spi_enable=2'b11.
- ISSUE (exactly 1 cycle): spi_start=1, busy=1, req_ready=0. Load counter with HOLD_CYCLES-1 and go to HOLD.
- HOLD:
  - busy=1, spi_start=0, req_ready=0; spi_instr and spi_enable stay stable.
  - Counter decrements each cycle. When it is 0 at an edge, go to IDLE.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles.
- Latency and throughput:
  - Accept edge to spi_start high: 1 cycle.
  - Minimum spacing between accepts: HOLD_CYCLES+2 cycles.
- Requester rules:
  - A requester may drop valid before it is granted; there is no penalty and nothing is captured.
  - The instruction is sampled only on the accept edge; later changes to the source are ignored.
- Fairness: with all three valid continuously, grants go self, left, right, self, ... No source waits more than 2 transactions.
- After leaving HOLD, spi_instr retains the last instruction; spi_enable returns to 2'b11 in IDLE.
- Reset mid-ISSUE or mid-HOLD: returns to IDLE next edge and drops the in-flight instruction. No req_ready pulses during the reset cycle.
- Simultaneous valid and reset: reset wins, no transfer.
- Counter width: 8 bits; no wrap is possible for legal HOLD_CYCLES.

Test Plan (HOLD_CYCLES=4 unless stated):
- Reset, then single request: req_valid=3'b001, self instr 32'd10000 -> req_ready=3'b001 in that cycle; next cycle spi_start=1, spi_enable=2'b00, spi_instr=10000, busy=1. busy stays high 5 cycles total, then spi_enable=2'b11, busy=0.
- All three valid continuously, instrs 30000/50000/10000 -> accepts in order self, left, right, self. spi_enable sequence 00, 01, 10, 00. spi_start pulses exactly 6 cycles apart.
- Only left valid with last=left (after a prior left grant) -> left is granted again, with no idle bubble beyond the required IDLE cycle.
- Source changes its instr during HOLD (left switches 50000 -> 7) -> spi_instr stays 50000 through HOLD. The next left accept captures 7.
- Reset asserted on the 2nd HOLD cycle -> next cycle state IDLE, busy=0, spi_enable=2'b11, spi_start=0. The next grant goes to self.
- HOLD_CYCLES=1 with continuous self request -> spi_start every 3 cycles; busy low exactly one cycle between transactions.
